// File: rtl/bg_trim_ctrl.sv
// Bandgap trim sequencer: power-up wait, then SAR search of the trim code against
// a synchronised comparator, with manual override for bench characterisation.
module bg_trim_ctrl #(
  parameter int TRIM_W      = 4,
  parameter int STARTUP_CYC = 8,
  parameter int SETTLE_CYC  = 4,
  parameter int CNT_W       = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ena,
  input  logic              i_start,
  input  logic              i_cmp_in,
  input  logic              i_trim_ovr,
  input  logic [TRIM_W-1:0] i_trim_man,
  output logic              o_bg_en,
  output logic [TRIM_W-1:0] o_trim_code,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_sat
);

  localparam int IDX_W = (TRIM_W > 2) ? $clog2(TRIM_W) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PWRUP  = 3'd1;
  localparam logic [2:0] ST_TRY    = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_SAMPLE = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [CNT_W-1:0] STARTUP_LD = CNT_W'(STARTUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_MAX    = IDX_W'(TRIM_W - 1);

  // A code pinned at either rail means the search ran out of trim range.
  function automatic logic f_is_sat(input logic [TRIM_W-1:0] code);
    return (&code) | (~|code);
  endfunction

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_cmp_meta;
  logic              r_cmp_s;
  logic              r_bg_en;
  logic [TRIM_W-1:0] r_trim_code;
  logic              r_busy;
  logic              r_done;
  logic              r_sat;
  logic [TRIM_W-1:0] w_code_try;
  logic [TRIM_W-1:0] w_code_dec;

  always_comb begin
    w_code_try = r_trim_code;
    w_code_try[r_idx] = 1'b1;
    w_code_dec = r_trim_code;
    if (r_cmp_s) begin
      w_code_dec[r_idx] = 1'b0;
    end else begin
      w_code_dec[r_idx] = r_trim_code[r_idx];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmp_meta <= 1'b0;
      r_cmp_s    <= 1'b0;
    end else begin
      r_cmp_meta <= i_cmp_in;
      r_cmp_s    <= r_cmp_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= IDX_MAX;
      r_bg_en     <= 1'b0;
      r_trim_code <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sat       <= 1'b0;
    end else if ((r_state != ST_IDLE) && (!i_ena || i_trim_ovr)) begin
      // Abort keeps the partial trim code and sat so they can be inspected.
      r_state <= ST_IDLE;
      r_bg_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (i_trim_ovr) begin
            r_trim_code <= i_trim_man;
            r_bg_en     <= i_ena;
            r_sat       <= 1'b0;
          end else if (i_ena && i_start) begin
            r_state     <= ST_PWRUP;
            r_bg_en     <= 1'b1;
            r_trim_code <= '0;
            r_sat       <= 1'b0;
            r_cnt       <= STARTUP_LD;
            r_busy      <= 1'b1;
          end else begin
            r_bg_en <= 1'b0;
          end
        end
        ST_PWRUP: begin
          if (r_cnt == '0) begin
            r_state <= ST_TRY;
            r_idx   <= IDX_MAX;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_TRY: begin
          r_trim_code <= w_code_try;
          r_cnt       <= SETTLE_LD;
          r_state     <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          r_trim_code <= w_code_dec;
          if (r_idx == '0) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_sat   <= f_is_sat(w_code_dec);
          end else begin
            r_idx   <= r_idx - IDX_W'(1);
            r_state <= ST_TRY;
          end
        end
        ST_DONE: begin
          // done is raised one cycle after entering DONE and dropped on restart.
          if (i_start) begin
            r_state     <= ST_PWRUP;
            r_bg_en     <= 1'b1;
            r_trim_code <= '0;
            r_sat       <= 1'b0;
            r_cnt       <= STARTUP_LD;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_bg_en <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_bg_en     = r_bg_en;
  assign o_trim_code = r_trim_code;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_sat       = r_sat;

endmodule

// File: doc/bg_trim_ctrl.md
Name: bg_trim_ctrl

Overview:
Digital sequencer for the bandgap reference analog macro in the bg user project. On request it powers the bandgap up and waits for start-up. It then runs a successive-approximation search over the bandgap trim code, using a comparator that checks the bandgap output against a target, and holds the result. It sits between the TT digital pins (ui_in/uo_out) and the analog macro's enable/trim inputs, and provides a manual trim override for bench characterisation.

Parameters:
TRIM_W, 4, trim code width (bits); legal range 2..8
STARTUP_CYC, 8, cycles in PWRUP after bg_en rises; must be >= 1
SETTLE_CYC, 4, settle cycles per trial bit; must be >= 2 (covers the 2-flop comparator sync)
CNT_W, 8, width of the shared wait counter; must hold max(STARTUP_CYC, SETTLE_CYC)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  block enable; low aborts to IDLE
start  input  1  calibration request, sampled as a level in IDLE or DONE
cmp_in  input  1  asynchronous comparator from the analog side; 1 = bandgap above target
trim_ovr  input  1  manual override select
trim_man  input  TRIM_W  manual trim code
bg_en  output  1  bandgap macro enable
trim_code  output  TRIM_W  trim code to the macro (registered)
busy  output  1  high in PWRUP/TRY/SETTLE/SAMPLE
done  output  1  high in DONE (calibration result valid)
sat  output  1  result saturated: final code is all-zeros or all-ones

Behaviour:
- Reset (async, rst_n=0): state=IDLE. bg_en=0, trim_code=0, busy=0, done=0, sat=0, counter=0, bit index=TRIM_W-1, sync flops=0. All outputs are registered.
- cmp_in passes through a 2-flop synchroniser to give cmp_s. Only cmp_s is used.
- States: IDLE, PWRUP, TRY, SETTLE, SAMPLE, DONE.
- IDLE: bg_en=0. If start=1, ena=1 and trim_ovr=0: go to PWRUP. On that edge set bg_en=1, trim_code=0, sat=0, counter=STARTUP_CYC-1.
- PWRUP: decrement the counter. At 0, go to TRY with bit index=TRIM_W-1.
- TRY (1 cycle): set trim_code[idx]=1. Load counter=SETTLE_CYC-1. Go to SETTLE.
- SETTLE: decrement the counter. At 0, go to SAMPLE.
- SAMPLE (1 cycle):
  - If cmp_s=1, clear trim_code[idx]; otherwise keep it.
  - If idx=0, go to DONE. sat is computed from the post-decision code.
  - Otherwise decrement idx and go to TRY.
- DONE: done=1, bg_en stays 1, trim_code held. start=1 restarts (go to PWRUP exactly as from IDLE, done cleared on that edge).
- Latency: done rises STARTUP_CYC + TRIM_W*(SETTLE_CYC+2) + 1 clock edges after the edge that samples start. With defaults that is 33.
- start while busy: ignored. No queuing.
- ena=0 in any state: next edge goes to IDLE, with bg_en=0, busy=0, done=0. trim_code and sat are held.
- trim_ovr=1:
  - In any non-IDLE state, abort to IDLE as for ena=0.
  - Then trim_code <= trim_man every cycle, bg_en=ena, sat=0, and start is ignored.
  - On release, trim_code keeps its last manual value until the next calibration.
- ena=0 and trim_ovr=1 together: bg_en=0, trim_code tracks trim_man.
- Reset mid-calibration: immediate async return to reset values. No partial result is retained.

Test Plan:
- Reset during SETTLE (assert rst_n=0 mid-search) -> all outputs 0 asynchronously, before the next clk edge; state IDLE.
- Defaults, comparator model cmp_in=(trim_code>9), start pulse -> busy=1 and bg_en=1 next cycle; trial codes 8,12,10,9; done=1 exactly 33 edges after start; trim_code=9, sat=0.
- cmp_in held 0 -> trim_code=15, sat=1. cmp_in held 1 -> trim_code=0, sat=1.
- start re-pulsed at cycle 10 of a run -> no restart, done still at edge 33. start in DONE -> done drops, new run completes 33 edges later.
- ena dropped during TRY of bit 1 -> IDLE next edge, bg_en=0, busy=0, done=0, trim_code held at its partial value.
- trim_ovr=1, trim_man=0x5 mid-calibration -> abort; trim_code=5 one cycle after the override is sampled; start ignored. After trim_ovr=0, trim_code stays 5 and start runs a normal calibration.
